sd_dat_block_rx: RTL

- Hardware receiver for SD 4-bit DAT block transfers from card to host.
- Replaces software bit-bang reads of the DAT lines.
- Detects the start bit and deserialises nibbles into 32-bit words in an internal FIFO; checks per-line CRC16 and the end bit.
- Exposes an Avalon-MM slave that the Nios II driver polls and pops; the SD clock divider supplies a sample strobe.

---
 rtl/sd_pkg.sv | 35 +++
 rtl/sd_crc16_serial.sv | 35 +++
 rtl/sd_dat_block_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT block receiver: FSM states, register map,
// STATUS bit positions and the CRC16-CCITT step used by the per-line checkers.
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      END
   } state_e;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_CRC_ERR  = 2;
   localparam int STAT_TIMEOUT  = 3;
   localparam int STAT_OVERFLOW = 4;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   localparam logic [15:0] CRC16_POLY = 16'h1021;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// One-bit serial CRC16-CCITT (init 0) for a single DAT line. Only compiled in
// when SD_DAT_RX_CRC_EN is defined; the receiver has no CRC logic otherwise.
`ifdef SD_DAT_RX_CRC_EN
module sd_crc16_serial
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i)
         crc_d = '0;
      else if (en_i)
         crc_d = crc16_step(crc_q, din_i);
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         crc_q <= '0;
      else
         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule
`endif

// File: rtl/sd_dat_block_rx.sv
// SD 4-bit DAT block receiver: start-bit detect, nibble deserialiser into a word FIFO,
// end-bit check and polled Avalon-MM registers. Per-line CRC16 checking needs SD_DAT_RX_CRC_EN.
module sd_dat_block_rx
   import sd_pkg::*;
#(
   parameter int BLOCK_BYTES = 512,
   parameter int FIFO_DEPTH  = 128,
   parameter int TIMEOUT_W   = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic        read_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [3:0]  sd_dat,
   input  logic        sd_sample
);

   localparam int NIBBLES = BLOCK_BYTES * 2;
   localparam int NIB_W   = $clog2(NIBBLES);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

   state_e               state_q, state_d;
   logic [3:0]           dat_s1_q, dat_s2_q, dat;
   logic [31:0]          rd_q, rd_d;
   logic [TIMEOUT_W-1:0] to_lim_q, to_lim_d, to_cnt_q, to_cnt_d;
   logic [27:0]          acc_q, acc_d;
   logic [NIB_W-1:0]     nib_q, nib_d;
   logic [3:0]           bit_q, bit_d;
   logic                 done_q, done_d, crc_err_q, crc_err_d;
   logic                 tmo_q, tmo_d, ovf_q, ovf_d;

   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     lvl_q, lvl_d;
   logic                 fifo_empty, fifo_full;

   logic                 wr_ctrl, wr_tmo, start_go, abort, pop;
   logic                 push_req, push_ok, flush, crc_mis, busy;
   logic [31:0]          push_word;
   logic [15:0]          lvl16;
   logic                 unused_wdata;

   assign dat          = dat_s2_q;
   assign busy         = (state_q != IDLE);
   assign wr_ctrl      = chipselect & ~write_n & (address == ADDR_CONTROL);
   assign wr_tmo       = chipselect & ~write_n & (address == ADDR_TIMEOUT);
   assign abort        = wr_ctrl & writedata[CTRL_ABORT];
   assign start_go     = wr_ctrl & writedata[CTRL_START] & ~writedata[CTRL_ABORT] & ~busy;
   assign flush        = start_go;
   assign fifo_empty   = (lvl_q == '0);
   assign fifo_full    = (lvl_q == LVL_W'(FIFO_DEPTH));
   assign pop          = chipselect & ~read_n & (address == ADDR_DATA) & ~fifo_empty;
   assign push_word    = {acc_q, dat};
   assign lvl16        = 16'(lvl_q);
   assign unused_wdata = ^writedata;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef SD_DAT_RX_CRC_EN
   logic [3:0][15:0] crc_val;
   logic [3:0]       crc_bad;
   logic             crc_en;

   assign crc_en = sd_sample & (state_q == DATA);

   for (genvar i = 0; i < 4; i++) begin : g_crc
      sd_crc16_serial u_crc (
         .clk     (clk),
         .reset_n (reset_n),
         .clr_i   (start_go),
         .en_i    (crc_en),
         .din_i   (dat[i]),
         .crc_o   (crc_val[i])
      );
      // Received CRC arrives MSB first, one bit per sample.
      assign crc_bad[i] = dat[i] ^ crc_val[i][4'd15 - bit_q];
   end
   assign crc_mis = |crc_bad;
`else
   assign crc_mis = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      acc_d     = acc_q;
      nib_d     = nib_q;
      bit_d     = bit_q;
      done_d    = done_q;
      crc_err_d = crc_err_q;
      tmo_d     = tmo_q;
      push_req  = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_go) begin
                  done_d    = 1'b0;
                  crc_err_d = 1'b0;
                  tmo_d     = 1'b0;
                  to_cnt_d  = '0;
                  acc_d     = '0;
                  nib_d     = '0;
                  bit_d     = '0;
                  state_d   = WAIT_START;
               end
            end
            WAIT_START: begin
               // Limit check first so a limit of 0 times out without any sample.
               if (to_cnt_q == to_lim_q) begin
                  tmo_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (sd_sample) begin
                  if (dat == 4'h0)
                     state_d = DATA;
                  else
                     to_cnt_d = to_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (sd_sample) begin
                  acc_d = {acc_q[23:0], dat};
                  nib_d = nib_q + 1'b1;
                  if (nib_q[2:0] == 3'd7)
                     push_req = 1'b1;
                  if (nib_q == NIB_W'(NIBBLES - 1))
                     state_d = CRC;
               end
            end
            CRC: begin
               if (sd_sample) begin
                  if (crc_mis)
                     crc_err_d = 1'b1;
                  bit_d = bit_q + 1'b1;
                  if (bit_q == 4'd15)
                     state_d = END;
               end
            end
            END: begin
               if (sd_sample) begin
                  if (dat != 4'hF)
                     crc_err_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      push_ok  = push_req & (~fifo_full | pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      lvl_d    = lvl_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         lvl_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_req & fifo_full & ~pop)
            ovf_d = 1'b1;
         if (push_ok)
            wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push_ok, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
         endcase
      end
   end

   always_comb begin
      to_lim_d = wr_tmo ? writedata[TIMEOUT_W-1:0] : to_lim_q;
      case (address)
         ADDR_DATA:    rd_d = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
         ADDR_STATUS:  rd_d = {lvl16, 11'b0, ovf_q, tmo_q, crc_err_q, done_q, busy};
         ADDR_TIMEOUT: rd_d = 32'(to_lim_q);
         default:      rd_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         dat_s1_q  <= 4'hF;
         dat_s2_q  <= 4'hF;
         rd_q      <= '0;
         to_lim_q  <= '1;
         to_cnt_q  <= '0;
         acc_q     <= '0;
         nib_q     <= '0;
         bit_q     <= '0;
         done_q    <= 1'b0;
         crc_err_q <= 1'b0;
         tmo_q     <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         lvl_q     <= '0;
      end else begin
         state_q   <= state_d;
         dat_s1_q  <= sd_dat;
         dat_s2_q  <= dat_s1_q;
         rd_q      <= rd_d;
         to_lim_q  <= to_lim_d;
         to_cnt_q  <= to_cnt_d;
         acc_q     <= acc_d;
         nib_q     <= nib_d;
         bit_q     <= bit_d;
         done_q    <= done_d;
         crc_err_q <= crc_err_d;
         tmo_q     <= tmo_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         lvl_q     <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= push_word;
   end

   assign readdata = rd_q;

endmodule
